// File: rtl/pulse_burst_sched.sv
// Round-robin scheduler sharing one pulse generator among N_REQ requesters; each grant runs a burst of req_len pulses.
// Grant, busy and the first pulse appear one cycle after req is sampled; an owner dropping req aborts the burst without a done strobe.
module pulse_burst_sched #(
    parameter int N_REQ  = 4,
    parameter int CNT_W  = 8,
    parameter int PERIOD = 5,
    parameter int HIGH   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic                   pulse
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PH_W  = $clog2(PERIOD);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  own_idx;
    logic [CNT_W-1:0]  rem;
    logic [PH_W-1:0]   phase;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  pick_nxt;
    logic [N_REQ-1:0]  pick_oh;
    logic [CNT_W-1:0]  pick_len;

    // Scan starting at rr_ptr; the first set request in rotated order wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_vld && req[IDX_W'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
        pick_nxt = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
        pick_oh  = N_REQ'(1) << pick_idx;
        pick_len = req_len[int'(pick_idx)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= '0;
            pulse   <= 1'b0;
            rr_ptr  <= '0;
            own_idx <= '0;
            rem     <= '0;
            phase   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant   <= pick_oh;
                        busy    <= 1'b1;
                        own_idx <= pick_idx;
                        rr_ptr  <= pick_nxt;
                        rem     <= pick_len;
                        phase   <= '0;
                        // A zero-length burst skips RUN so rem can never wrap.
                        if (pick_len != '0) begin
                            state <= RUN;
                            pulse <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= pick_oh;
                        end
                    end
                end
                RUN: begin
                    if (!req[own_idx]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        pulse <= 1'b0;
                    end else if (phase == PH_LAST) begin
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= grant;
                            pulse <= 1'b0;
                        end else begin
                            phase <= '0;
                            pulse <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        pulse <= (32'(phase) + 32'd1) < HIGH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
